image_loader: RTL and testbench
===============================

// Module: image_loader
// PURPOSE
//  Upstream fill stage for memory_export: accepts the puzzle image as a stream of 32-bit words
//  (column-major, row 0 first) and packs IMG_ROWS words into one column vector.
//  Each vector goes out on the memory write port (we/addr_write/write_data) at addr = column index.
//  Raises load_done after IMG_COLS columns; waffle_solver starts from that.
//  Sustains one word per clock: a column is handed to a separate write register while the next fills.
// PARAMETERS
//  IMG_ROWS  32  words per column vector (write_data depth)
//  IMG_COLS  32  column vectors per image (addresses 0..IMG_COLS-1)
// PORTS
//  clk         input   1                   system clock, rising edge
//  rst         input   1                   asynchronous, active-low reset (0 = in reset)
//  start       input   1                   1-cycle pulse: begin/restart load at column 0
//  in_valid    input   1                   in_word valid
//  in_ready    output  1                   loader accepts word this cycle
//  in_word     input   32                  image word
//  in_last     input   1                   marks final word of image
//  we          output  1                   memory write strobe, 1 cycle per column
//  addr_write  output  32                  column index, zero-extended
//  write_data  output  [IMG_ROWS-1:0][31:0] packed column; write_data[r] = row r
//  load_done   output  1                   sticky: full image written
//  error       output  1                   sticky: in_last framing violation
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; in_ready, we, load_done, error = 0; addr_write = 0;
//   write_data = 0; row_idx = col_idx = 0.
//  States: IDLE -> (start) FILL -> (last word of last column accepted) DONE; FILL -> ERR on framing fault.
//   DONE and ERR hold until start, which clears load_done/error and re-enters FILL at col 0, row 0.
//  in_ready = 1 only in FILL and start = 0; accept = in_valid & in_ready.
//  On accept: word stored at fill_buf[row_idx]; row_idx++.
//   On accept at row_idx = IMG_ROWS-1: next edge loads write_data with fill_buf plus the new word,
//   addr_write <= col_idx, we <= 1 for exactly one cycle; row_idx <= 0; col_idx++.
//   Latency: last word of a column accepted in cycle N -> we = 1 in cycle N+1.
//   Accepting continues in cycle N+1 (no bubble).
//  write_data/addr_write hold their last values while we = 0.
//  Column IMG_COLS-1 completes: final we pulse, then DONE; load_done = 1 from the same cycle as that we.
//  Framing rules, checked on accept:
//   - in_last = 1 on any word other than (col IMG_COLS-1, row IMG_ROWS-1) -> ERR.
//   - in_last = 0 on that final word -> ERR.
//   In both cases no we for that column; error = 1 next cycle; in_ready = 0.
//  start while in FILL: abort; partial column discarded; no we issued.
//   A word presented in the start cycle is not accepted, and a pending we already launched completes.
//  start while in IDLE, DONE or ERR: same restart; a start while we = 1 does not cancel that pulse.
//  in_valid while not ready: ignored, no state change.
//  Counters: row_idx is $clog2(IMG_ROWS) bits, col_idx is $clog2(IMG_COLS)+1 bits; both wrap only via reset/start.
// STRUCTURE
//  waffle_pkg holds:
//   - IMG_ROWS/IMG_COLS default constants
//   - typedef enum logic [2:0] {IDLE, FILL, DONE, ERR} loader_state_t
//   - typedef logic [31:0] word_t
//  Single module, no sub-module. fill_buf is IMG_ROWS x word_t, indexed write. The write register
//  is separate from fill_buf (double buffer).
// TESTING
//  1 rst=0 mid-run with we=1 -> all outputs 0 immediately (async); after rst=1, state IDLE, in_ready=0.
//  2 start, then 1024 words back-to-back with word=col*32+row and in_last on the final word.
//    Expect: 32 we pulses, each at addr k with write_data[r]=k*32+r; in_ready continuously 1;
//    load_done=1 on the cycle of the addr 31 pulse.
//  3 Random in_valid gaps (~50%) -> same memory contents as test 2; we exactly one cycle after
//    each 32nd accepted word.
//  4 in_last on word 40 (col 1, row 8) -> error=1 next cycle; only the addr 0 write occurs;
//    in_ready=0 until start.
//  5 Final word without in_last -> error=1, no addr 31 write, load_done=0.
//  6 start after 50 words -> no write of partial col 1.
//    Reload of 1024 words -> writes restart at addr 0; load_done=1 at end.

Source files
------------

// File: rtl/waffle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : waffle_pkg
//  Description : Shared constants and types for the waffle puzzle datapath
//                (image loader, memory export, solver).
//  Revision    : 1.0  initial release
// ============================================================================
package waffle_pkg;

    // Default image geometry: words per column vector, columns per image
    localparam int c_IMG_ROWS = 32;
    localparam int c_IMG_COLS = 32;

    // Loader control states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        DONE = 3'd2,
        ERR  = 3'd3
    } loader_state_t;

    // One image word
    typedef logic [31:0] word_t;

endpackage
`default_nettype wire

// File: rtl/image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : image_loader
//  Description : Packs a column-major stream of 32-bit image words into
//                column vectors and writes each one to memory at its column
//                index. A fill buffer collects the next column while the
//                write register presents the previous one, so the input runs
//                at one word per clock. Flags completion and framing faults.
//  Revision    : 1.0  initial release
// ============================================================================
module image_loader
    import waffle_pkg::*;
#(
    parameter int IMG_ROWS = c_IMG_ROWS,
    parameter int IMG_COLS = c_IMG_COLS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_word,
    input  logic                     in_last,
    output logic                     we,
    output logic [31:0]              addr_write,
    output logic [IMG_ROWS-1:0][31:0] write_data,
    output logic                     load_done,
    output logic                     error
);

    localparam int c_RW = $clog2(IMG_ROWS);
    localparam int c_CW = $clog2(IMG_COLS) + 1;
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_ROWS - 1);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_COLS - 1);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [c_RW-1:0]            r_row_idx;
    logic [c_CW-1:0]            r_col_idx;
    word_t                      r_fill_buf [IMG_ROWS];
    logic [IMG_ROWS-1:0][31:0]  w_col_vec;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_col_end;
    logic                       w_final_pos;
    logic                       w_frame_err;
    logic                       w_write;

    logic                       r_we;
    logic [31:0]                r_addr_write;
    logic [IMG_ROWS-1:0][31:0]  r_write_data;
    logic                       r_load_done;
    logic                       r_error;

    // Handshake decode; in_last must appear exactly on the image's last word
    always_comb begin
        w_in_ready  = (r_state == FILL) && !start;
        w_accept    = in_valid && w_in_ready;
        w_col_end   = (r_row_idx == c_ROW_LAST);
        w_final_pos = w_col_end && (r_col_idx == c_COL_LAST);
        w_frame_err = w_accept && (in_last != w_final_pos);
        w_write     = w_accept && w_col_end && !w_frame_err;
    end

    // Completed column: buffered rows with the incoming word in its slot
    always_comb begin
        for (int r = 0; r < IMG_ROWS; r++) begin
            w_col_vec[r] = r_fill_buf[r];
        end
        w_col_vec[r_row_idx] = in_word;
    end

    // Next-state logic; start restarts the load from any state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = FILL;
            FILL: begin
                if (start)                   w_state_nxt = FILL;
                else if (w_frame_err)        w_state_nxt = ERR;
                else if (w_write && w_final_pos) w_state_nxt = DONE;
            end
            DONE: if (start) w_state_nxt = FILL;
            ERR:  if (start) w_state_nxt = FILL;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Row/column position of the next word; start drops any partial column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_idx <= '0;
            r_col_idx <= '0;
        end else if (start) begin
            r_row_idx <= '0;
            r_col_idx <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_row_idx <= '0;
                r_col_idx <= r_col_idx + c_CW'(1);
            end else begin
                r_row_idx <= r_row_idx + c_RW'(1);
            end
        end
    end

    // Fill buffer storage; pure datapath, contents qualified by row_idx
    always_ff @(posedge clk) begin
        if (w_accept) r_fill_buf[r_row_idx] <= in_word;
    end

    // Write register and sticky status; a launched we pulse always completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_addr_write <= '0;
            r_write_data <= '0;
            r_load_done  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_addr_write <= 32'(r_col_idx);
                r_write_data <= w_col_vec;
            end
            if (start) begin
                r_load_done <= 1'b0;
                r_error     <= 1'b0;
            end else begin
                if (w_write && w_final_pos) r_load_done <= 1'b1;
                if (w_frame_err)            r_error     <= 1'b1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign we         = r_we;
    assign addr_write = r_addr_write;
    assign write_data = r_write_data;
    assign load_done  = r_load_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_loader
//  Description : Self-checking bench for image_loader. A driver issues
//                stimulus and pushes expected memory writes into a scoreboard;
//                a monitor pops and compares whenever we is high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_image_loader;

    localparam int ROWS = 32;
    localparam int COLS = 32;
    localparam int NW   = ROWS * COLS;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_word;
    logic                   in_last;
    logic                   we;
    logic [31:0]            addr_write;
    logic [ROWS-1:0][31:0]  write_data;
    logic                   load_done;
    logic                   error;

    image_loader #(.IMG_ROWS(ROWS), .IMG_COLS(COLS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_last    (in_last),
        .we         (we),
        .addr_write (addr_write),
        .write_data (write_data),
        .load_done  (load_done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                     cyc;
        logic [31:0]            addr;
        logic [ROWS-1:0][31:0]  data;
    } wr_t;

    wr_t         sb[$];
    int unsigned img[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          m_loading = 0;
    bit          m_done    = 0;
    bit          m_err     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},        32'(we),        32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_error"},     32'(error),     32'd0);
        chk({tag, "_addr"},      addr_write,     32'd0);
        chk({tag, "_wdata0"},    32'(write_data == '0), 32'd1);
    endtask

    // One clock of stimulus; the model decides what the loader should do
    task automatic drive(input bit v, input logic [31:0] w, input bit l, input bit s, output bit acc);
        bit exp_ready;
        int exp_cyc;
        int pos;
        bit fin;
        wr_t e;
        @(negedge clk);
        in_valid = v;
        in_word  = w;
        in_last  = l;
        start    = s;
        #1;
        exp_ready = m_loading && !s;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc     = v && exp_ready;
        exp_cyc = cyc + 1;
        @(posedge clk);
        if (s) begin
            m_loading = 1;
            m_done    = 0;
            m_err     = 0;
            img.delete();
        end else if (acc) begin
            pos = img.size();
            img.push_back(w);
            fin = (pos == NW - 1);
            if (l != fin) begin
                m_err     = 1;
                m_loading = 0;
            end else if ((pos + 1) % ROWS == 0) begin
                e.cyc  = exp_cyc;
                e.addr = 32'(pos / ROWS);
                for (int r = 0; r < ROWS; r++) e.data[r] = img[pos - ROWS + 1 + r];
                sb.push_back(e);
                if (fin) begin
                    m_done    = 1;
                    m_loading = 0;
                end
            end
        end
    endtask

    // Present words idx = col*ROWS+row until n are accepted
    task automatic feed(input int n, input int last_at, input int gap_pct);
        int idx   = 0;
        int guard = 0;
        bit acc;
        bit v;
        while (idx < n && guard < 40 * n + 100) begin
            v = ($urandom_range(99) >= gap_pct);
            drive(v, 32'(idx), (idx == last_at), 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        if (idx < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL feed_timeout: actual=%0d required=%0d words accepted", idx, n);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_start();
        bit acc;
        drive(1'b0, 32'd0, 1'b0, 1'b1, acc);
    endtask

    // Monitor: status flags every cycle, memory writes against the scoreboard
    always @(negedge clk) begin
        wr_t e;
        bit  bad;
        int  br;
        if (rst) begin
            chk("load_done", 32'(load_done), 32'(m_done));
            chk("error",     32'(error),     32'(m_err));
            if (we) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_we: actual addr=%0d required=no write", addr_write);
                end else begin
                    e = sb.pop_front();
                    chk("we_cycle", 32'(cyc), 32'(e.cyc));
                    chk("addr_write", addr_write, e.addr);
                    bad = 0;
                    br  = 0;
                    for (int r = 0; r < ROWS; r++) begin
                        if (!bad && write_data[r] !== e.data[r]) begin
                            bad = 1;
                            br  = r;
                        end
                    end
                    n_checks++;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL write_data addr %0d row %0d: actual=%0h required=%0h",
                                 e.addr, br, write_data[br], e.data[br]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Test 1: asynchronous reset while a we pulse is high
        do_start();
        feed(ROWS, -1, 0);
        #1;
        chk("t1_we_high", 32'(we), 32'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("t1_async");
        sb.delete();
        img.delete();
        m_loading = 0;
        m_done    = 0;
        m_err     = 0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Test 2: full image back-to-back
        do_start();
        feed(NW, NW - 1, 0);
        idle(3);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_done", 32'(load_done), 32'd1);

        // Test 3: full image with ~50% valid gaps
        do_start();
        feed(NW, NW - 1, 50);
        idle(3);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_done", 32'(load_done), 32'd1);

        // Test 4: early in_last at col 1 row 8
        do_start();
        feed(41, 40, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0, acc);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Test 5: final word without in_last
        do_start();
        feed(NW, -1, 0);
        idle(3);
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_done", 32'(load_done), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Test 6: restart after 50 words (word offered in start cycle), reload
        do_start();
        feed(50, -1, 0);
        drive(1'b1, 32'd50, 1'b0, 1'b1, acc);
        feed(NW, NW - 1, 0);
        idle(3);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_done", 32'(load_done), 32'd1);

        // Test 7: start in the cycle a we pulse is high, then gapped reload
        do_start();
        feed(ROWS, -1, 0);
        do_start();
        feed(NW, NW - 1, 30);
        idle(3);
        chk("t7_sb_empty", 32'(sb.size()), 32'd0);
        chk("t7_done", 32'(load_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
